// File: rtl/score_keeper.sv
// Score engine for the spaceship game: hit/miss/game-over pulses in,
// saturating score, streak bonus and high score out to the 7-seg decoder.
module score_keeper #(
  parameter int SCORE_W      = 9,
  parameter int MAX_SCORE    = 511,
  parameter int HIT_POINTS   = 5,
  parameter int MISS_PENALTY = 2,
  parameter int BONUS_EVERY  = 8,
  parameter int BONUS_POINTS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  input  logic               game_over,
  input  logic               show_high,
  output logic [SCORE_W-1:0] number,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [3:0]         streak,
  output logic               running,
  output logic               new_high
);

  localparam int SW2 = SCORE_W + 2;
  localparam logic [SCORE_W-1:0] PEN  = SCORE_W'(MISS_PENALTY);
  localparam logic [SCORE_W-1:0] MAXV = SCORE_W'(MAX_SCORE);
  localparam logic [SW2-1:0] MAXW = SW2'(MAX_SCORE);
  localparam logic [SW2-1:0] HITW = SW2'(HIT_POINTS);
  localparam logic [SW2-1:0] BONW = SW2'(BONUS_POINTS);
  localparam logic [4:0]     BEV  = 5'(BONUS_EVERY);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    COMMIT,
    OVER
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [SCORE_W-1:0] score_n;
  logic [3:0]         streak_n;
  logic [4:0]         streak_inc;
  logic               bonus;
  logic [SW2-1:0]     sum;

  assign streak_inc = {1'b0, streak} + 5'd1;
  assign bonus      = (streak_inc == BEV);
  // Two spare bits keep score + hit + bonus from wrapping before saturation
  assign sum        = SW2'(score) + HITW + (bonus ? BONW : '0);
  assign running    = (state == PLAY);

  always_comb begin
    state_n  = state;
    score_n  = score;
    streak_n = streak;
    unique case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n  = PLAY;
          score_n  = '0;
          streak_n = '0;
        end
      end
      PLAY: begin
        if (miss) begin
          score_n  = (score < PEN) ? '0 : score - PEN;
          streak_n = '0;
        end else if (hit) begin
          score_n  = (sum > MAXW) ? MAXV : sum[SCORE_W-1:0];
          streak_n = bonus ? 4'd0 : streak_inc[3:0];
        end
        if (game_over) state_n = COMMIT;
      end
      COMMIT: state_n = OVER;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      score      <= '0;
      streak     <= '0;
      high_score <= '0;
      new_high   <= 1'b0;
      number     <= '0;
    end else begin
      state    <= state_n;
      score    <= score_n;
      streak   <= streak_n;
      new_high <= 1'b0;
      if (state == COMMIT && score > high_score) begin
        high_score <= score;
        new_high   <= 1'b1;
      end
      number <= (state != PLAY && show_high) ? high_score : score;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: linear steps, hand-computed expectations.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, hit, miss, game_over, show_high;
  logic [8:0] number, score, high_score;
  logic [3:0] streak;
  logic       running, new_high;

  int tests = 0;
  int fails = 0;

  score_keeper dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hit       (hit),
    .miss      (miss),
    .game_over (game_over),
    .show_high (show_high),
    .number    (number),
    .score     (score),
    .high_score(high_score),
    .streak    (streak),
    .running   (running),
    .new_high  (new_high)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic s, input logic h,
                      input logic m, input logic g);
    start = s; hit = h; miss = m; game_over = g;
    tick();
    start = 0; hit = 0; miss = 0; game_over = 0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  task automatic misses(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1; start = 0; hit = 0; miss = 0; game_over = 0; show_high = 0;
    #2;
    check("rst_score", score, 0);
    check("rst_number", number, 0);
    check("rst_running", running, 0);
    #1 rst = 0;

    // IDLE ignores hit
    step(0, 1, 0, 0);
    check("idle_hit_score", score, 0);
    check("idle_running", running, 0);

    // Game A: three hits
    step(1, 0, 0, 0);
    check("a_running", running, 1);
    hits(3);
    check("a_score", score, 15);
    check("a_streak", streak, 3);
    check("a_number_lag", number, 10);
    tick();
    check("a_number", number, 15);
    step(0, 0, 0, 1);
    check("a_commit_run", running, 0);
    check("a_commit_nh", new_high, 0);
    tick();
    check("a_high", high_score, 15);
    check("a_nh", new_high, 1);

    // Game B: bonus, floor, priority
    step(1, 0, 0, 0);
    check("b_restart", score, 0);
    hits(8);
    check("b_bonus_score", score, 50);
    check("b_bonus_streak", streak, 0);
    hits(1);
    check("b_post_score", score, 55);
    check("b_post_streak", streak, 1);
    misses(27);
    check("b_one", score, 1);
    misses(1);
    check("b_floor", score, 0);
    hits(4);
    check("b_twenty", score, 20);
    step(0, 1, 1, 0);
    check("b_prio_score", score, 18);
    check("b_prio_streak", streak, 0);
    step(0, 0, 0, 1);
    tick();
    check("b_high", high_score, 18);

    // Game C: set high to 30
    step(1, 0, 0, 0);
    hits(6);
    check("c_score", score, 30);
    step(0, 0, 0, 1);
    tick();
    check("c_high", high_score, 30);

    // Game D: raise high to 50
    step(1, 0, 0, 0);
    hits(8);
    check("d_score", score, 50);
    step(0, 0, 0, 1);
    check("d_commit_high", high_score, 30);
    check("d_commit_nh", new_high, 0);
    tick();
    check("d_high", high_score, 50);
    check("d_nh_on", new_high, 1);
    tick();
    check("d_nh_off", new_high, 0);

    // Game E: hit together with game_over, no new high
    step(1, 0, 0, 0);
    hits(3);
    step(0, 1, 0, 1);
    check("e_commit_score", score, 20);
    check("e_commit_run", running, 0);
    tick();
    check("e_high", high_score, 50);
    check("e_nh", new_high, 0);
    show_high = 1;
    tick();
    check("e_show_high", number, 50);
    show_high = 0;
    tick();
    check("e_show_score", number, 20);

    // Game F: saturation
    step(1, 0, 0, 0);
    hits(80);
    check("f_500", score, 500);
    misses(1);
    hits(2);
    check("f_508", score, 508);
    hits(1);
    check("f_sat", score, 511);
    check("f_sat_streak", streak, 3);
    hits(1);
    check("f_hold", score, 511);
    step(1, 0, 0, 0);
    check("f_start_ign_run", running, 1);
    check("f_start_ign_score", score, 511);
    check("f_start_ign_streak", streak, 4);
    show_high = 1;
    tick();
    check("f_play_number", number, 511);
    show_high = 0;

    // Game G: async reset mid-game
    step(0, 0, 0, 1);
    tick();
    step(1, 0, 0, 0);
    hits(6);
    misses(4);
    hits(3);
    check("g_score", score, 37);
    check("g_streak", streak, 3);
    #3 rst = 1;
    #1;
    check("g_rst_score", score, 0);
    check("g_rst_high", high_score, 0);
    check("g_rst_streak", streak, 0);
    check("g_rst_number", number, 0);
    check("g_rst_running", running, 0);
    check("g_rst_nh", new_high, 0);
    #1 rst = 0;
    step(0, 1, 0, 0);
    check("g_idle_hit", score, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
